square_f32: RTL

Sequential IEEE-754 single-precision squarer: computes a·a and is the inverse-direction companion of the float32 square-root block in the processing element. It is used by the PE to square values for verification and variance/norm computations, and to check square-root results (sqrt(x)² ≈ x). The mantissa product is formed by an iterative 24-cycle shift-add multiplier, not a combinational multiplier, so the block sits beside the divider and square-root units under the same start/ready style of control.

---
 rtl/square_f32.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/square_f32.sv
// Sequential float32 squarer: 24-cycle shift-add mantissa multiply followed by
// a single normalise/pack cycle. Denormals flush to zero, rounding truncates.
module square_f32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    output logic        rdy,
    output logic        busy,
    output logic [31:0] sq
);

    localparam int WIDTH         = 32;
    localparam int EXPONENTWIDTH = 8;
    localparam int MANTISSAWIDTH = 23;
    localparam int SIGW          = MANTISSAWIDTH + 1;
    localparam int PRODW         = 2 * SIGW;

    localparam logic [WIDTH-1:0] POS_INF = 32'h7F80_0000;
    localparam logic [WIDTH-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [WIDTH-1:0] ZERO    = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [4:0]               count_q, count_d;
    logic [PRODW-1:0]         mcand_q, mcand_d;
    logic [SIGW-1:0]          mplier_q, mplier_d;
    logic [PRODW-1:0]         prod_q, prod_d;
    logic signed [9:0]        expR_q, expR_d;
    logic [WIDTH-1:0]         sq_q, sq_d;

    logic [EXPONENTWIDTH-1:0] expIn;
    logic [MANTISSAWIDTH-1:0] manIn;
    logic signed [9:0]        twoExp;
    logic signed [9:0]        expN;
    logic [MANTISSAWIDTH-1:0] frac;
    logic                     unusedSign;

    assign expIn      = a[30:23];
    assign manIn      = a[22:0];
    assign unusedSign = a[31];
    assign twoExp     = signed'({1'b0, expIn, 1'b0});

    // The product of two values in [1,2) lies in [1,4); bit 47 marks the upper half.
    assign expN = prod_q[PRODW-1] ? (expR_q + 10'sd1) : expR_q;
    assign frac = prod_q[PRODW-1] ? prod_q[46:24] : prod_q[45:23];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            expR_q   <= '0;
            sq_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            expR_q   <= expR_d;
            sq_q     <= sq_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        expR_d   = expR_q;
        sq_d     = sq_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (expIn == '0) begin
                        sq_d    = ZERO;
                        state_d = DONE;
                    end else if (expIn == {EXPONENTWIDTH{1'b1}}) begin
                        sq_d    = (manIn == '0) ? POS_INF : QNAN;
                        state_d = DONE;
                    end else begin
                        mcand_d  = {{SIGW{1'b0}}, 1'b1, manIn};
                        mplier_d = {1'b1, manIn};
                        prod_d   = '0;
                        count_d  = '0;
                        expR_d   = twoExp - 10'sd127;
                        state_d  = MUL;
                    end
                end
            end

            MUL: begin
                // Multiplier bits are consumed LSB first while the multiplicand walks left.
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (count_q == 5'd23) begin
                    count_d = '0;
                    state_d = NORM;
                end else begin
                    count_d = count_q + 5'd1;
                end
            end

            NORM: begin
                expR_d = expN;
                if (expN >= 10'sd255) begin
                    sq_d = POS_INF;
                end else if (expN <= 10'sd0) begin
                    sq_d = ZERO;
                end else begin
                    sq_d = {1'b0, expN[7:0], frac};
                end
                state_d = DONE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rdy  = (state_q == DONE);
    assign busy = (state_q == MUL) || (state_q == NORM);
    assign sq   = sq_q;

endmodule
